// File: rtl/mpb_pkg.sv
// rtl/mpb_pkg.sv - shared MPB types, constants and round-robin pick helper
package mpb_pkg;

  localparam int MPB_ADDR_W   = 32;
  localparam int MPB_DATA_W   = 32;
  localparam int MPB_MAX_MAIN = 16;

  localparam logic [31:0] MPB_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic {
    MPB_IDLE = 1'b0,
    MPB_BUSY = 1'b1
  } mpb_state_e;

  typedef struct packed {
    logic                  wr;
    logic [MPB_ADDR_W-1:0] addr;
    logic [MPB_DATA_W-1:0] wdata;
  } mpb_req_t;

  typedef struct packed {
    logic [MPB_DATA_W-1:0] rdata;
  } mpb_rsp_t;

  // First set request at or above ptr, wrapping at MPB_MAX_MAIN. Unused upper
  // request bits must be zero, which makes the wrap equivalent to modulo N.
  function automatic logic [MPB_MAX_MAIN-1:0] rr_pick(
    input logic [MPB_MAX_MAIN-1:0] req,
    input logic [3:0]              ptr
  );
    logic [MPB_MAX_MAIN-1:0] gnt;
    logic                    found;
    logic [3:0]              k;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < MPB_MAX_MAIN; i++) begin
      k = ptr + 4'(i);
      if (!found && req[k]) begin
        gnt[k] = 1'b1;
        found  = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/mpb_rr_picker.sv
// rtl/mpb_rr_picker.sv - combinational round-robin priority selector
module mpb_rr_picker
  import mpb_pkg::*;
#(
  parameter int NUM_MAIN = 2,
  localparam int PTR_W   = $clog2(NUM_MAIN)
) (
  input  logic [NUM_MAIN-1:0] i_req,
  input  logic [PTR_W-1:0]    i_ptr,
  output logic [NUM_MAIN-1:0] o_gnt,
  output logic [PTR_W-1:0]    o_idx
);

  logic [MPB_MAX_MAIN-1:0] w_gnt_full;

  assign w_gnt_full = rr_pick(MPB_MAX_MAIN'(i_req), 4'(i_ptr));
  assign o_gnt      = w_gnt_full[NUM_MAIN-1:0];

  // Upper bits are always zero because their requests are zero-padded.
  if (NUM_MAIN < MPB_MAX_MAIN) begin : g_hi
    logic w_unused_hi;
    assign w_unused_hi = |w_gnt_full[MPB_MAX_MAIN-1:NUM_MAIN];
  end

  // Encode the one-hot grant into an index.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < NUM_MAIN; i++) begin
      if (o_gnt[i]) o_idx = PTR_W'(i);
    end
  end

endmodule

// File: rtl/mpb_rr_arbiter.sv
// rtl/mpb_rr_arbiter.sv - N-to-1 MPB round-robin arbiter with stall timeout
module mpb_rr_arbiter
  import mpb_pkg::*;
#(
  parameter int          NUM_MAIN = 2,
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          TIMEOUT  = 256,
  parameter logic [31:0] ERR_DATA = MPB_ERR_DATA
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_MAIN-1:0]        m_vld,
  input  logic [NUM_MAIN-1:0]        m_wr,
  input  logic [NUM_MAIN*ADDR_W-1:0] m_addr,
  input  logic [NUM_MAIN*DATA_W-1:0] m_wdata,
  output logic [NUM_MAIN-1:0]        m_rdy,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       s_vld,
  output logic                       s_wr,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [DATA_W-1:0]          s_wdata,
  input  logic                       s_rdy,
  input  logic [DATA_W-1:0]          s_rdata,
  output logic [NUM_MAIN-1:0]        grant,
  output logic                       timeout_err
);

  localparam int                PTR_W = $clog2(NUM_MAIN);
  localparam logic [DATA_W-1:0] ERR_W = DATA_W'(ERR_DATA);

  mpb_state_e          r_state, w_state_nxt;
  logic [NUM_MAIN-1:0] r_grant, w_grant_nxt;
  logic [PTR_W-1:0]    r_gidx, w_gidx_nxt;
  logic [PTR_W-1:0]    r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0]    w_ptr_succ;
  logic [NUM_MAIN-1:0] w_pick_gnt;
  logic [PTR_W-1:0]    w_pick_idx;
  logic                w_busy;
  logic                w_abort;
  logic                w_stall;

  mpb_rr_picker #(
    .NUM_MAIN (NUM_MAIN)
  ) u_picker (
    .i_req (m_vld),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx)
  );

  assign w_busy      = (r_state == MPB_BUSY);
  assign w_stall     = s_vld && !s_rdy;
  assign w_ptr_succ  = (int'(r_gidx) == NUM_MAIN - 1) ? '0 : r_gidx + 1'b1;
  assign grant       = r_grant;
  assign timeout_err = w_abort;

  // Stall counter; only exists when a timeout limit is configured.
  if (TIMEOUT > 0) begin : g_tmo
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt;

    // Count stalled BUSY cycles; held at zero outside BUSY so each grant starts fresh.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt <= '0;
      end else if (!w_busy) begin
        r_cnt <= '0;
      end else if (w_stall) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_abort = w_busy && (r_cnt == CNT_W'(TIMEOUT));
  end else begin : g_no_tmo
    assign w_abort = 1'b0;
  end

  // Arbitration state, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= MPB_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_gidx  <= w_gidx_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next state: arbitrate in IDLE; leave BUSY on abort, handshake or dropped request.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      MPB_IDLE: begin
        if (|m_vld) begin
          w_state_nxt = MPB_BUSY;
          w_grant_nxt = w_pick_gnt;
          w_gidx_nxt  = w_pick_idx;
        end
      end
      MPB_BUSY: begin
        if (w_abort || (s_vld && s_rdy)) begin
          w_state_nxt = MPB_IDLE;
          w_grant_nxt = '0;
          w_ptr_nxt   = w_ptr_succ;
        end else if (!m_vld[r_gidx]) begin
          // Main withdrew without a handshake: no transfer, pointer unchanged.
          w_state_nxt = MPB_IDLE;
          w_grant_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = MPB_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // Bus muxing: route the granted main to the secondary, or the abort response back.
  always_comb begin
    s_vld   = 1'b0;
    s_wr    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    m_rdy   = '0;
    m_rdata = s_rdata;
    if (w_busy) begin
      s_vld         = m_vld[r_gidx] && !w_abort;
      s_wr          = m_wr[r_gidx];
      s_addr        = m_addr[int'(r_gidx)*ADDR_W +: ADDR_W];
      s_wdata       = m_wdata[int'(r_gidx)*DATA_W +: DATA_W];
      m_rdy[r_gidx] = w_abort ? 1'b1 : s_rdy;
      if (w_abort) m_rdata = ERR_W;
    end
  end

endmodule

// File: doc/mpb_rr_arbiter.md
Name: mpb_rr_arbiter

Overview:
- Parametrised N-to-1 Matrix Peripheral Bus (MPB) arbiter: NUM_MAIN main ports share one secondary port.
- Arbitration is round-robin; one transaction is granted at a time.
- A per-transaction stall timeout aborts hung secondaries with an error response.
- Successor to the 1:1 MPB point-to-point wiring; it is the shared-bus element for multi-main DV benches and subsystems.

Parameters:
- NUM_MAIN, 2, number of main ports (2..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 256, stall-cycle limit before abort; 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on a timeout abort; truncated or zero-extended to DATA_W.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- m_vld  in  NUM_MAIN  per-main request valid.
- m_wr  in  NUM_MAIN  per-main write (1) / read (0).
- m_addr  in  NUM_MAIN*ADDR_W  per-main address, main i at slice [i*ADDR_W +: ADDR_W].
- m_wdata  in  NUM_MAIN*DATA_W  per-main write data, packed the same way.
- m_rdy  out  NUM_MAIN  per-main ready.
- m_rdata  out  DATA_W  read data, broadcast to all mains.
- s_vld  out  1  secondary request valid.
- s_wr  out  1  secondary write.
- s_addr  out  ADDR_W  secondary address.
- s_wdata  out  DATA_W  secondary write data.
- s_rdy  in  1  secondary ready.
- s_rdata  in  DATA_W  secondary read data.
- grant  out  NUM_MAIN  one-hot registered grant; all zero when idle.
- timeout_err  out  1  one-cycle pulse on a timeout abort.

Behaviour:
- MPB transfer rule: a transfer completes on any cycle where vld && rdy. Read data is valid in that same cycle. A main must hold vld/wr/addr/wdata stable until rdy.
- Reset (async assert, sync deassert):
  - grant = 0, state = IDLE, rr_ptr = 0, timeout counter = 0, timeout_err = 0.
  - Combinational outputs then resolve to: s_vld = s_wr = 0, s_addr = s_wdata = 0, m_rdy = 0.
- State machine:
  - IDLE: if any m_vld is set, pick the first set bit searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NUM_MAIN-1, 0, ...). Register grant one-hot and go to BUSY. No request means stay in IDLE.
  - BUSY (granted main g):
    - s_vld/s_wr/s_addr/s_wdata are combinationally muxed from main g.
    - m_rdy[g] = s_rdy; all other m_rdy bits are 0.
    - m_rdata = s_rdata.
  - BUSY exit on completion: when s_vld && s_rdy, go to IDLE, clear grant, rr_ptr = (g+1) mod NUM_MAIN.
  - BUSY exit on dropped request: if m_vld[g] drops without a handshake (protocol violation), go to IDLE, clear grant, leave rr_ptr unchanged, no transfer.
- Latency: m_vld to s_vld is 1 cycle. A new arbitration costs one idle bubble cycle, so sustained throughput is at most one transfer per 2 cycles.
- Round-robin fairness: with all mains requesting continuously, grants rotate 0,1,...,NUM_MAIN-1,0,... No main waits more than NUM_MAIN transactions.
- Outside BUSY: s_* are driven to 0 and m_rdy = 0. m_rdata still follows s_rdata but is meaningless without rdy.
- Timeout (TIMEOUT > 0):
  - Counter width is $clog2(TIMEOUT+1). It increments each BUSY cycle with s_vld && !s_rdy and clears on entering BUSY.
  - Abort cycle: the cycle when the count equals TIMEOUT.
  - In the abort cycle: s_vld = 0, m_rdy[g] = 1, m_rdata = ERR_DATA (for writes too), timeout_err = 1.
  - Next cycle: IDLE, rr_ptr = (g+1) mod NUM_MAIN.
- Timeout vs. late ready: if s_rdy arrives in the abort cycle it is ignored, because s_vld is already 0. The abort wins.
- TIMEOUT = 0: the counter is not built and timeout_err is tied to 0.
- Reset mid-transaction: outputs drop to reset values immediately, asynchronously. No completion is reported.

Decomposition:
- Package mpb_pkg holds:
  - the MPB request struct (wr, addr, wdata) and response struct (rdata), parametrised via localparam defaults ADDR_W/DATA_W = 32;
  - constant MPB_ERR_DATA = 32'hDEAD_BEEF;
  - function rr_pick(req, ptr) returning the one-hot grant.
- One sub-module, mpb_rr_picker: combinational round-robin priority selector (NUM_MAIN param; req and ptr inputs; one-hot gnt and index outputs). It is reused by future MPB fabrics.

Test Plan:
- Single main (NUM_MAIN=2): main 0 writes addr 0x100, wdata 0xA5A5_0001, s_rdy=1 -> s_vld rises 1 cycle after m_vld with matching fields; m_rdy[0] pulses once; grant goes 01 then 00.
- Read: main 1 reads 0x200, s_rdata = 0x1234_5678, s_rdy delayed 3 cycles -> m_rdy[1] asserts on the 4th BUSY cycle with m_rdata = 0x1234_5678; m_rdy[0] stays 0 throughout.
- Fairness (NUM_MAIN=4): all m_vld held continuously for 8 transactions, s_rdy=1 -> grant order 0,1,2,3,0,1,2,3; each transaction is 2 cycles.
- Timeout (TIMEOUT=8): main 0 read, s_rdy held 0 -> on the 8th stall cycle m_rdy[0]=1, m_rdata=0xDEAD_BEEF, timeout_err pulses once, s_vld=0 in that cycle; the next pending main 1 is granted afterwards.
- Late ready: s_rdy rises exactly in the abort cycle -> no secondary transfer, error response still returned.
- Reset mid-op: assert reset_n=0 while BUSY with s_rdy=0 -> grant, s_vld and m_rdy are 0 the same cycle. After release, main 0 (rr_ptr=0) wins when both mains request.
